// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder: memory map, timer register
// layout and the timer FSM state encoding.
package data_bus_responder_pkg;

    // Data RAM: 3072 words, byte addresses 0x0000_0000 .. 0x0000_2FFF
    localparam int          DM_WORDS_DEF = 3072;
    localparam logic [31:0] DM_LIMIT     = 32'h0000_3000;

    // Timer register block
    localparam logic [31:0] TC_BASE_DEF   = 32'h0000_7F00;
    localparam logic [1:0]  TC_OFF_CTRL   = 2'd0;
    localparam logic [1:0]  TC_OFF_PRESET = 2'd1;
    localparam logic [1:0]  TC_OFF_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings; anything other than RELOAD behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data-memory port as seen between the core's MEM stage and the responder.
interface data_bus_responder_if;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        output m_inst_addr,
        input  m_data_rdata
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        input  m_inst_addr,
        output m_data_rdata
    );

endinterface

// File: rtl/data_bus_responder_tc_timer.sv
// Memory-mapped countdown timer: CTRL / PRESET / COUNT registers, a four-state
// FSM, and a level interrupt gated by CTRL.IM.
module tc_timer
    import data_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e   state, state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_next;
    logic        irq_flag;
    logic        flag_set, flag_clr, en_clr;
    logic        auto_reload;

    assign auto_reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= TC_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and the register updates the FSM requests
    always_comb begin
        state_next = state;
        count_next = count;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        en_clr     = 1'b0;
        case (state)
            TC_IDLE: if (ctrl[CTRL_EN]) state_next = TC_LOAD;
            TC_LOAD: begin
                count_next = preset;
                state_next = TC_CNT;
            end
            TC_CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_next = TC_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // PRESET of 0 lands here on the first count, same as 1
                    count_next = 32'd0;
                    flag_set   = 1'b1;
                    state_next = TC_INT;
                end
            end
            TC_INT: begin
                if (auto_reload) begin
                    flag_clr   = 1'b1;
                    state_next = TC_LOAD;
                end else begin
                    en_clr     = 1'b1;
                    state_next = TC_IDLE;
                end
            end
            default: state_next = TC_IDLE;
        endcase
    end

    // Timer registers; a CPU write is applied last so it overrides the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            count <= count_next;
            if (flag_set)      irq_flag <= 1'b1;
            else if (flag_clr) irq_flag <= 1'b0;
            if (en_clr) ctrl[CTRL_EN] <= 1'b0;
            if (wr_en && off == TC_OFF_CTRL) begin
                ctrl     <= wdata[3:0];
                irq_flag <= 1'b0;
            end
            if (wr_en && off == TC_OFF_PRESET) preset <= wdata;
        end
    end

    // Register read mux
    always_comb begin
        rdata = 32'd0;
        case (off)
            TC_OFF_CTRL:   rdata = {28'd0, ctrl};
            TC_OFF_PRESET: rdata = preset;
            TC_OFF_COUNT:  rdata = count;
            default:       rdata = 32'd0;
        endcase
    end

    assign irq = irq_flag & ctrl[CTRL_IM];

endmodule

// File: rtl/data_bus_responder.sv
// Responder for the CPU data-memory port: word-organised RAM, timer block,
// address decode and a zero-latency read mux. Always returns a full word.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEF,
    parameter logic [31:0] TC_BASE  = TC_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    data_bus_responder_if.slave   bus,
    output logic                  irq
);

    localparam int          AW      = $clog2(DM_WORDS);
    localparam logic [29:0] TC_WORD = TC_BASE[31:2];

    logic [31:0] mem [DM_WORDS];
    logic [29:0] waddr;
    logic [AW-1:0] ram_idx;
    logic        in_ram, in_tc;
    logic        ram_we, tc_we;
    logic [1:0]  tc_off;
    logic [31:0] ram_word, merged, tc_rdata;
    logic [1:0]  unused_addr_bits;

    assign waddr            = bus.m_data_addr[31:2];
    assign unused_addr_bits = bus.m_data_addr[1:0];
    assign ram_idx          = waddr[AW-1:0];
    assign in_ram           = (waddr < 30'(DM_WORDS));
    assign in_tc            = (waddr >= TC_WORD) && (waddr <= TC_WORD + 30'd2);
    assign tc_off           = 2'(waddr - TC_WORD);
    assign ram_we           = in_ram && (bus.m_data_byteen != 4'd0);
    assign tc_we            = in_tc && (bus.m_data_byteen == 4'b1111);
    assign ram_word         = mem[ram_idx];

    // Byte-lane merge of write data into the currently stored word
    always_comb begin
        merged = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.m_data_byteen[i]) merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
        end
    end

    // RAM storage: cleared on reset, merged-word write otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'd0;
        end else if (ram_we) begin
            mem[ram_idx] <= merged;
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", bus.m_inst_addr, {bus.m_data_addr[31:2], 2'b00}, merged);
`endif
        end
    end

    tc_timer u_tc (
        .clk   (clk),
        .reset (reset),
        .wr_en (tc_we),
        .off   (tc_off),
        .wdata (bus.m_data_wdata),
        .rdata (tc_rdata),
        .irq   (irq)
    );

    // Read mux: unmapped space reads as zero
    always_comb begin
        if (in_ram)     bus.m_data_rdata = ram_word;
        else if (in_tc) bus.m_data_rdata = tc_rdata;
        else            bus.m_data_rdata = 32'd0;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder side of the CPU data-memory port. It services every access the pipeline issues on m_data_addr, m_data_wdata and m_data_byteen, and returns m_data_rdata in the same cycle.
- Contains a word-organised data RAM and one memory-mapped countdown timer with an interrupt output.
- Sits at top level beside the mips core. Byte extraction and sign-extension for loads stay in the core's MEM stage; this block always returns a full word.

Parameters:
- DM_WORDS, 3072, data RAM depth in 32-bit words (12 KiB, byte addresses 0x0000_0000 to 0x0000_2FFF).
- TC_BASE, 32'h0000_7F00, timer register base address (CTRL at +0, PRESET at +4, COUNT at +8).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- m_data_addr  in  32  byte address from the core's MEM stage.
- m_data_wdata  in  32  write data, already lane-aligned by the core.
- m_data_byteen  in  4  byte write enables; 0 means read or no access.
- m_inst_addr  in  32  PC of the MEM-stage instruction; used only for the simulation write trace.
- m_data_rdata  out  32  combinational read data.
- irq  out  1  timer interrupt request, level.

Behaviour:
- Address decode uses the word address m_data_addr[31:2]. There are three regions:
  - RAM: addr < DM_WORDS*4.
  - TC: TC_BASE to TC_BASE+0xB.
  - Everything else is unmapped.
- Reads are combinational with zero latency; m_data_rdata is always driven.
  - RAM region: returns mem[addr[13:2]].
  - TC region: returns CTRL zero-extended, PRESET, or COUNT.
  - Unmapped region: returns 32'h0.
- RAM writes happen at posedge when byteen != 0. Lane i writes m_data_wdata[8i+7:8i] into byte i of the word; unselected lanes are unchanged.
- Read-during-write to the same word returns the old value in that cycle and the new value from the next cycle.
- Writes to unmapped addresses and to COUNT are ignored.
- TC registers accept a write only when byteen == 4'b1111; partial writes are ignored.
- CTRL is 4 bits:
  - [0] EN, count enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, other values behave as 00.
  - [3] IM, interrupt mask (1 = irq enabled).
- irq = irq_flag & CTRL.IM.
- Timer FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Otherwise, if COUNT > 1, COUNT <= COUNT-1. Otherwise COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE 00: EN <= 0; go to IDLE. irq_flag holds until the next accepted CTRL write, which clears it.
  - INT, MODE 01: irq_flag <= 0; go to LOAD. The flag is therefore a single-cycle pulse per period.
- Timing with PRESET = N ≥ 1: irq_flag rises N cycles after the LOAD edge. PRESET = 0 behaves as N = 1.
- A PRESET write while counting does not disturb COUNT; it takes effect at the next LOAD.
- If a CPU CTRL write and the FSM's EN clear (INT, MODE 00) land on the same edge, the CPU write wins for the CTRL contents. The FSM still goes to IDLE, and the accepted write clears irq_flag.
- Reset values:
  - All RAM words are 0.
  - CTRL, PRESET, COUNT and irq_flag are 0; the FSM is in IDLE; irq is 0.
  - m_data_rdata therefore reads 0 everywhere after reset.
- Reset asserted mid-count returns the timer to IDLE at that edge, with no irq.
- Simulation only: on each accepted RAM write, $display "@pc: *addr <= data" using m_inst_addr, the word-aligned address, and the merged word.

Decomposition:
- Shared package holds:
  - TC_BASE offsets and CTRL bit indices (EN, MODE, IM).
  - MODE encodings.
  - The FSM state enumeration (2-bit).
  - DM region limit.
- One sub-module, tc_timer:
  - Owns CTRL, PRESET, COUNT, irq_flag and the FSM.
  - Takes a decoded write strobe, a 2-bit register offset and wdata.
  - Returns read data and irq.
- data_bus_responder keeps the RAM, address decode and read mux.

Test Plan:
1. After reset, read 0x0, 0x2FFC and 0x7F08 -> all return 32'h0; irq = 0.
2. Write 32'hAABBCCDD to 0x10 with byteen 1111, then write 32'h0000_1100 with byteen 0010 -> reading 0x10 returns 32'hAABB11DD; a read in the same cycle as the second write returns 32'hAABBCCDD.
3. Write PRESET = 3, then CTRL = 4'b1001 (one-shot, IM, EN) -> COUNT reads 3, 2, 1, 0 on successive cycles. irq rises and stays high, CTRL.EN reads 0, and the next full CTRL write drops irq.
4. Write PRESET = 2, then CTRL = 4'b1011 (auto-reload) -> irq is a single-cycle pulse repeating every 4 cycles (LOAD plus 2 counts plus INT); COUNT reloads to 2 each period.
5. Start a count with PRESET = 100. After 5 cycles, write CTRL with EN = 0 -> COUNT holds at its value and there is no irq. Also write CTRL with byteen 0011 -> the write is ignored and CTRL is unchanged.
6. Assert reset mid-count -> COUNT, CTRL and irq return to 0 next cycle; a write to 0x5000 does not change any readable location.
